// File: rtl/traffic_pkg.sv
// Shared lamp encodings and junction state type.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package traffic_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b001;

    // Encoding 3'd7 is unused and treated as illegal by the controller.
    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED1    = 3'd2,
        PED_WALK    = 3'd3,
        SIDE_GREEN  = 3'd4,
        SIDE_YELLOW = 3'd5,
        ALL_RED2    = 3'd6
    } state_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down counter that flags when the current phase may end.
// Latency: load takes effect at the next edge; done is combinational from the count.
// Backpressure: none; holds at zero until reloaded.
module phase_timer #(
    parameter int              CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Count down to zero and park there; a load always takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_junction_ctrl.sv
// Junction sequencer: main road, side road and pedestrian crossing lamps.
// Latency: Moore outputs, lamps follow the state register with no extra delay.
// Backpressure: none; requests are sampled every cycle, pedestrian requests are latched.
module traffic_junction_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_MAIN_T = 8,
    parameter int GREEN_SIDE_T = 5,
    parameter int YELLOW_T     = 2,
    parameter int ALLRED_T     = 1,
    parameter int WALK_T       = 4,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_pending
);

    // Timer reload values: a phase of length T counts T-1 down to 0.
    localparam logic [CNT_W-1:0] LD_GREEN_MAIN = CNT_W'(GREEN_MAIN_T - 1);
    localparam logic [CNT_W-1:0] LD_GREEN_SIDE = CNT_W'(GREEN_SIDE_T - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW     = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED     = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] LD_WALK       = CNT_W'(WALK_T - 1);

    state_t           state;
    state_t           next_state;
    logic             tmr_done;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             ped_pend_q;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_GREEN_MAIN)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State register; reset drops straight into main green with no yellow.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MAIN_GREEN;
        end else begin
            state <= next_state;
        end
    end

    // Pedestrian latch: the clear on entering the walk phase beats a same-cycle press.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pend_q <= 1'b0;
        end else if (next_state == PED_WALK && state != PED_WALK) begin
            ped_pend_q <= 1'b0;
        end else if (ped_req && state != PED_WALK) begin
            ped_pend_q <= 1'b1;
        end
    end

    // Next-state and timer reload; phases only end once the timer reaches zero.
    always_comb begin
        next_state = state;
        case (state)
            MAIN_GREEN:  if (tmr_done && (side_req || ped_pend_q)) next_state = MAIN_YELLOW;
            MAIN_YELLOW: if (tmr_done) next_state = ALL_RED1;
            ALL_RED1:    if (tmr_done) next_state = ped_pend_q ? PED_WALK : SIDE_GREEN;
            PED_WALK:    if (tmr_done) next_state = side_req ? SIDE_GREEN : ALL_RED2;
            SIDE_GREEN:  if (tmr_done) next_state = SIDE_YELLOW;
            SIDE_YELLOW: if (tmr_done) next_state = ALL_RED2;
            ALL_RED2:    if (tmr_done) next_state = MAIN_GREEN;
            default:     next_state = MAIN_GREEN;
        endcase

        // Any state change (including recovery from an illegal code) reloads the timer.
        tmr_load = (next_state != state);
        case (next_state)
            MAIN_GREEN:  tmr_val = LD_GREEN_MAIN;
            MAIN_YELLOW: tmr_val = LD_YELLOW;
            SIDE_YELLOW: tmr_val = LD_YELLOW;
            PED_WALK:    tmr_val = LD_WALK;
            SIDE_GREEN:  tmr_val = LD_GREEN_SIDE;
            default:     tmr_val = LD_ALLRED;
        endcase
    end

    // Lamp decode from the state register; unknown codes show all red.
    always_comb begin
        main_light = RED;
        side_light = RED;
        walk       = 1'b0;
        case (state)
            MAIN_GREEN:  main_light = GREEN;
            MAIN_YELLOW: main_light = YELLOW;
            SIDE_GREEN:  side_light = GREEN;
            SIDE_YELLOW: side_light = YELLOW;
            PED_WALK:    walk       = 1'b1;
            default:     walk       = 1'b0;
        endcase
    end

    assign ped_pending = ped_pend_q;

endmodule
